dmem_arbiter: RTL and testbench

//   Shares the single-ported data memory (dmem) between two requesters:
//   the CPU load/store path (port C) and a debug/loader port (port D, used
//   by the bench to preload or inspect memory).
//   - Sits between the cpu datapath and dmem.
//   - Serialises accesses through an IDLE/ISSUE/WAIT/RESP state machine.
//   - Chooses between simultaneous requests by round-robin or fixed CPU priority.

---
 rtl/dmem_arbiter_if.sv | 52 +++++
 rtl/dmem_arbiter.sv | 133 +++++++++++++
 tb/tb_dmem_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the dmem arbiter.
// Carries two requester ports (c_* for the CPU, d_* for debug/loader), the memory side and the busy flag.
// The slave modport is the arbiter's view. The master modport is the
// environment's view: it drives requests and m_rdata.
interface dmem_arbiter_if #(
  parameter int AW = 64,
  parameter int DW = 64
);
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_gnt;
  logic          c_rvalid;
  logic [DW-1:0] c_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  logic          busy;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_gnt, c_rvalid, c_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output m_en, m_we, m_addr, m_wdata,
    input  m_rdata,
    output busy
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_gnt, c_rvalid, c_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_en, m_we, m_addr, m_wdata,
    output m_rdata,
    input  busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory.
// Accesses are serialised through IDLE -> ISSUE -> (WAIT -> RESP) -> IDLE.
// Every output is registered. Request lines are looked at only in IDLE.
module dmem_arbiter #(
  parameter int AW           = 64,
  parameter int DW           = 64,
  parameter int RD_LAT       = 1,
  parameter int CPU_PRIORITY = 0
) (
  input logic           clk,
  input logic           reset_n,
  dmem_arbiter_if.slave bus
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          sel;       // current winner: 0 = C, 1 = D
  logic          last_gnt;  // last granted port: 0 = C, 1 = D
  logic          pick_d;

  logic          c_gnt;
  logic          c_rvalid;
  logic [DW-1:0] c_rdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          busy;

  assign bus.c_gnt    = c_gnt;
  assign bus.c_rvalid = c_rvalid;
  assign bus.c_rdata  = c_rdata;
  assign bus.d_gnt    = d_gnt;
  assign bus.d_rvalid = d_rvalid;
  assign bus.d_rdata  = d_rdata;
  assign bus.m_en     = m_en;
  assign bus.m_we     = m_we;
  assign bus.m_addr   = m_addr;
  assign bus.m_wdata  = m_wdata;
  assign bus.busy     = busy;

  // Winner selection: a lone request wins; on a tie C wins under fixed
  // priority, otherwise the port that was not granted last time wins.
  always_comb begin
    pick_d = 1'b0;
    if (bus.d_req && !bus.c_req) begin
      pick_d = 1'b1;
    end else if (bus.d_req && bus.c_req && (CPU_PRIORITY == 0) && !last_gnt) begin
      pick_d = 1'b1;
    end
  end

  // Arbitration FSM. The m_* registers double as the latched request fields,
  // so nothing on the input side reaches the memory combinationally.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      sel      <= 1'b0;
      last_gnt <= 1'b1;
      c_gnt    <= 1'b0;
      c_rvalid <= 1'b0;
      c_rdata  <= '0;
      d_gnt    <= 1'b0;
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
      m_en     <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      busy     <= 1'b0;
    end else begin
      c_gnt    <= 1'b0;
      d_gnt    <= 1'b0;
      c_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      m_en     <= 1'b0;
      m_we     <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.c_req || bus.d_req) begin
            sel     <= pick_d;
            m_en    <= 1'b1;
            m_we    <= pick_d ? bus.d_we    : bus.c_we;
            m_addr  <= pick_d ? bus.d_addr  : bus.c_addr;
            m_wdata <= pick_d ? bus.d_wdata : bus.c_wdata;
            c_gnt   <= !pick_d;
            d_gnt   <= pick_d;
            busy    <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          last_gnt <= sel;
          if (m_we) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt   <= CW'(RD_LAT - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            if (sel) d_rdata <= bus.m_rdata;
            else     c_rdata <= bus.m_rdata;
            c_rvalid <= !sel;
            d_rvalid <= sel;
            state    <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter.
// u0: RD_LAT=1 with round-robin. u1: RD_LAT=3 with CPU priority.
// Each instance has a simple memory model attached. Expected grants and
// read data are queued when stimulus is driven, then popped and compared
// when the DUT reports them.
module tb_dmem_arbiter;

  logic clk;
  logic reset_n;

  dmem_arbiter_if #(.AW(64), .DW(64)) i0 ();
  dmem_arbiter_if #(.AW(64), .DW(64)) i1 ();

  dmem_arbiter #(.AW(64), .DW(64), .RD_LAT(1), .CPU_PRIORITY(0)) u0 (
    .clk(clk), .reset_n(reset_n), .bus(i0)
  );
  dmem_arbiter #(.AW(64), .DW(64), .RD_LAT(3), .CPU_PRIORITY(1)) u1 (
    .clk(clk), .reset_n(reset_n), .bus(i1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: read data appears RD_LAT cycles after m_en; any other
  // cycle shows a junk pattern so a mistimed capture is visible.
  localparam logic [63:0] JUNK = 64'hBAD0_BAD0_BAD0_BAD0;
  logic [63:0] mem0 [256];
  logic [63:0] mem1 [256];
  logic [63:0] pipe0;
  logic [63:0] pipe1 [3];

  assign i0.m_rdata = pipe0;
  assign i1.m_rdata = pipe1[2];

  always @(posedge clk) begin
    if (i0.m_en && i0.m_we) mem0[i0.m_addr[7:0]] <= i0.m_wdata;
    pipe0 <= (i0.m_en && !i0.m_we) ? mem0[i0.m_addr[7:0]] : JUNK;
    if (i1.m_en && i1.m_we) mem1[i1.m_addr[7:0]] <= i1.m_wdata;
    pipe1[0] <= (i1.m_en && !i1.m_we) ? mem1[i1.m_addr[7:0]] : JUNK;
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
  end

  typedef struct {
    logic        c_gnt, d_gnt, c_rvalid, d_rvalid;
    logic [63:0] c_rdata, d_rdata;
    logic        m_en, m_we;
    logic [63:0] m_addr, m_wdata;
    logic        busy;
  } obs_t;

  int total = 0;
  int bad   = 0;
  obs_t o0, o1;

  int          exp_gnt0 [$];
  int          exp_gnt1 [$];
  logic [63:0] exp_rd0  [$];
  logic [63:0] exp_rd1  [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic obs_t get(input int u);
    obs_t o;
    if (u == 0) begin
      o.c_gnt = i0.c_gnt;   o.d_gnt = i0.d_gnt;
      o.c_rvalid = i0.c_rvalid; o.d_rvalid = i0.d_rvalid;
      o.c_rdata = i0.c_rdata; o.d_rdata = i0.d_rdata;
      o.m_en = i0.m_en; o.m_we = i0.m_we;
      o.m_addr = i0.m_addr; o.m_wdata = i0.m_wdata; o.busy = i0.busy;
    end else begin
      o.c_gnt = i1.c_gnt;   o.d_gnt = i1.d_gnt;
      o.c_rvalid = i1.c_rvalid; o.d_rvalid = i1.d_rvalid;
      o.c_rdata = i1.c_rdata; o.d_rdata = i1.d_rdata;
      o.m_en = i1.m_en; o.m_we = i1.m_we;
      o.m_addr = i1.m_addr; o.m_wdata = i1.m_wdata; o.busy = i1.busy;
    end
    return o;
  endfunction

  task automatic drive(input int u, input int p, input logic req, input logic we,
                       input logic [63:0] addr, input logic [63:0] wdata);
    if (u == 0 && p == 0) begin
      i0.c_req = req; i0.c_we = we; i0.c_addr = addr; i0.c_wdata = wdata;
    end else if (u == 0) begin
      i0.d_req = req; i0.d_we = we; i0.d_addr = addr; i0.d_wdata = wdata;
    end else if (p == 0) begin
      i1.c_req = req; i1.c_we = we; i1.c_addr = addr; i1.c_wdata = wdata;
    end else begin
      i1.d_req = req; i1.d_we = we; i1.d_addr = addr; i1.d_wdata = wdata;
    end
  endtask

  // Scoreboard for one instance: exclusivity, grant order, read data.
  task automatic score(input int u, input obs_t o);
    int          g_exp;
    logic [63:0] d_exp;
    chk($sformatf("u%0d_gnt_exclusive", u), 64'(o.c_gnt & o.d_gnt), 64'd0);
    chk($sformatf("u%0d_rvalid_exclusive", u), 64'(o.c_rvalid & o.d_rvalid), 64'd0);
    if (o.c_gnt === 1'b1 || o.d_gnt === 1'b1) begin
      if (u == 0 && exp_gnt0.size() > 0)      g_exp = exp_gnt0.pop_front();
      else if (u == 1 && exp_gnt1.size() > 0) g_exp = exp_gnt1.pop_front();
      else                                    g_exp = -1;
      chk($sformatf("u%0d_gnt_order", u), 64'(o.d_gnt ? 1 : 0), 64'(g_exp));
    end
    if (o.c_rvalid === 1'b1 || o.d_rvalid === 1'b1) begin
      if (u == 0 && exp_rd0.size() > 0)      d_exp = exp_rd0.pop_front();
      else if (u == 1 && exp_rd1.size() > 0) d_exp = exp_rd1.pop_front();
      else                                   d_exp = 64'hFFFF_FFFF_FFFF_FFFF;
      chk($sformatf("u%0d_rdata", u), o.d_rvalid ? o.d_rdata : o.c_rdata, d_exp);
    end
  endtask

  // One cycle: advance to the falling edge, sample both instances, score.
  task automatic cyc();
    @(negedge clk);
    o0 = get(0);
    o1 = get(1);
    score(0, o0);
    score(1, o1);
  endtask

  initial begin
    int rv_cyc, cg_cyc, n_c, n_d, n_c1, n_d1, seen;
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0); drive(0, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0); drive(1, 1, 0, 0, 0, 0);
    repeat (3) cyc();

    // Reset state
    chk("rst_busy",    64'(o0.busy),  0);
    chk("rst_c_gnt",   64'(o0.c_gnt), 0);
    chk("rst_m_en",    64'(o0.m_en),  0);
    chk("rst_c_rdata", o0.c_rdata,    0);
    chk("rst_m_addr",  o1.m_addr,     0);
    chk("rst_m_wdata", o1.m_wdata,    0);
    reset_n = 1'b1;

    // T1: C write 0x10 <- 0xDEAD on u0
    drive(0, 0, 1, 1, 64'h10, 64'hDEAD);
    exp_gnt0.push_back(0);
    chk("t1_busy_c0", 64'(o0.busy), 0);
    cyc();
    chk("t1_c_gnt",   64'(o0.c_gnt), 1);
    chk("t1_m_en",    64'(o0.m_en),  1);
    chk("t1_m_we",    64'(o0.m_we),  1);
    chk("t1_m_addr",  o0.m_addr,     64'h10);
    chk("t1_m_wdata", o0.m_wdata,    64'hDEAD);
    drive(0, 0, 0, 0, 0, 0);
    cyc();
    chk("t1_busy_c2", 64'(o0.busy), 0);

    // T2: C read 0x10 on u0, rvalid expected in cycle 3
    drive(0, 0, 1, 0, 64'h10, 0);
    exp_gnt0.push_back(0);
    exp_rd0.push_back(64'hDEAD);
    rv_cyc = -1; seen = 0;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      if (k == 1) drive(0, 0, 0, 0, 0, 0);
      if (o0.c_rvalid === 1'b1 && rv_cyc < 0) rv_cyc = k;
      if (o0.d_rvalid === 1'b1) seen = 1;
    end
    chk("t2_rvalid_cycle", 64'(rv_cyc), 64'd3);
    chk("t2_c_rdata",      o0.c_rdata,  64'hDEAD);
    chk("t2_d_rvalid",     64'(seen),   64'd0);

    // T3: both ports request every IDLE; u0 alternates, u1 grants only C
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    drive(0, 0, 1, 1, 64'h20, 64'hC0C0); drive(0, 1, 1, 1, 64'h28, 64'hD0D0);
    drive(1, 0, 1, 1, 64'h20, 64'hC0C0); drive(1, 1, 1, 1, 64'h28, 64'hD0D0);
    exp_gnt0.push_back(0); exp_gnt0.push_back(1);
    exp_gnt0.push_back(0); exp_gnt0.push_back(1);
    repeat (4) exp_gnt1.push_back(0);
    n_c = 0; n_d = 0; n_c1 = 0; n_d1 = 0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (o0.c_gnt === 1'b1) n_c++;
      if (o0.d_gnt === 1'b1) n_d++;
      if (o1.c_gnt === 1'b1) n_c1++;
      if (o1.d_gnt === 1'b1) n_d1++;
      if (k == 8) begin
        drive(0, 0, 0, 0, 0, 0); drive(0, 1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0); drive(1, 1, 0, 0, 0, 0);
      end
    end
    chk("t3_rr_c_count",  64'(n_c),  64'd2);
    chk("t3_rr_d_count",  64'(n_d),  64'd2);
    chk("t3_pri_c_count", 64'(n_c1), 64'd4);
    chk("t3_pri_d_count", 64'(n_d1), 64'd0);
    repeat (2) cyc();

    // T4: D read on u1 (RD_LAT=3), C write raised in cycle 2
    drive(1, 1, 1, 1, 64'h40, 64'h1234_5678_9ABC_DEF0);
    exp_gnt1.push_back(1);
    cyc();
    drive(1, 1, 0, 0, 0, 0);
    cyc();
    drive(1, 1, 1, 0, 64'h40, 0);
    exp_gnt1.push_back(1);
    exp_rd1.push_back(64'h1234_5678_9ABC_DEF0);
    rv_cyc = -1; cg_cyc = -1;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      if (k == 1) drive(1, 1, 0, 0, 0, 0);
      if (k == 3) chk("t4_busy_wait", 64'(o1.busy), 64'd1);
      if (o1.d_rvalid === 1'b1 && rv_cyc < 0) rv_cyc = k;
      if (o1.c_gnt === 1'b1 && cg_cyc < 0) begin
        cg_cyc = k;
        drive(1, 0, 0, 0, 0, 0);
      end
      if (k == 2) begin
        drive(1, 0, 1, 1, 64'h50, 64'h55);
        exp_gnt1.push_back(0);
      end
    end
    chk("t4_d_rvalid_cycle", 64'(rv_cyc), 64'd5);
    chk("t4_c_gnt_cycle",    64'(cg_cyc), 64'd7);
    chk("t4_d_rdata",        o1.d_rdata,  64'h1234_5678_9ABC_DEF0);

    // T5: reset during the WAIT cycle of a C read on u0
    drive(0, 0, 1, 0, 64'h10, 0);
    exp_gnt0.push_back(0);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    cyc();
    chk("t5_busy_wait", 64'(o0.busy), 64'd1);
    reset_n = 1'b0;
    cyc();
    chk("t5_c_gnt",    64'(o0.c_gnt),    64'd0);
    chk("t5_m_en",     64'(o0.m_en),     64'd0);
    chk("t5_busy",     64'(o0.busy),     64'd0);
    chk("t5_c_rdata",  o0.c_rdata,       64'd0);
    reset_n = 1'b1;
    seen = (o0.c_rvalid === 1'b1) ? 1 : 0;
    repeat (5) begin
      cyc();
      if (o0.c_rvalid === 1'b1) seen = 1;
    end
    chk("t5_no_rvalid", 64'(seen), 64'd0);

    // T6: C read request held high across its grant issues a second access
    drive(0, 0, 1, 0, 64'h10, 0);
    exp_gnt0.push_back(0); exp_gnt0.push_back(0);
    exp_rd0.push_back(64'hDEAD); exp_rd0.push_back(64'hDEAD);
    n_c = 0; n_d = 0;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      if (o0.c_gnt === 1'b1) n_c++;
      if (o0.c_rvalid === 1'b1) n_d++;
      if (k == 5) drive(0, 0, 0, 0, 0, 0);
    end
    chk("t6_protocol_repeat_gnt",    64'(n_c), 64'd2);
    chk("t6_protocol_repeat_rvalid", 64'(n_d), 64'd2);

    chk("sb_empty", 64'(exp_gnt0.size() + exp_gnt1.size() + exp_rd0.size() + exp_rd1.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
